conv_tap_sequencer: RTL and testbench
=====================================

# conv_tap_sequencer

Sequencer for one convolution layer core (for example the fire squeeze core), whose weight ROM and MAC clear logic advance one tap per enabled cycle. It walks output pixels in raster order and, for each pixel, every kernel tap and input channel. Each cycle it emits the input-feature-map RAM address, a zero-padding flag and the core enable. It supports back-pressure from the feature-map RAM and reports layer completion with a start/done handshake.

## Interface
Parameters:
- `W_IN`, 128: input map width and height (square).
- `CHIN`, 64: input channels.
- `KERNEL_DIM`, 3: kernel width and height.
- `STRIDE`, 1: convolution stride.
- `PAD`, 1: zero padding on each border.
- `WOUT`, (W_IN+2*PAD-KERNEL_DIM)/STRIDE+1: output width and height (derived).
- `ADDR_W`, $clog2(W_IN*W_IN*CHIN): width of the ifm RAM address.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle pulse that starts the layer; honoured only in IDLE.
- `stall`, in, 1: RAM not ready; freezes the sequence.
- `layer_en`, out, 1: core enable; one tap is consumed per high cycle.
- `ifm_addr`, out, ADDR_W: ifm RAM address for the current tap.
- `pad_zero`, out, 1: current tap lies in the padding; the consumer substitutes pixel 0.
- `tap_last`, out, 1: current tap is the last tap (of KERNEL_DIM²·CHIN) of the output pixel.
- `busy`, out, 1: high in RUN and DONE.
- `done`, out, 1: one-cycle pulse after the final tap.

## Operation
- The tap order inside a pixel is ky (outer), then kx, then c (inner). This matches the weight ROM index (ky·KERNEL_DIM+kx)·CHIN+c.
- Output pixels are visited with oy outer and ox inner.
- Counters: oy, ox, ky, kx, c, all registered.
  - c wraps at CHIN−1 and carries into kx.
  - kx wraps at KERNEL_DIM−1 and carries into ky.
  - ky wraps at KERNEL_DIM−1 and carries into ox.
  - ox wraps at WOUT−1 and carries into oy.
- Input coordinates are iy = oy·STRIDE+ky−PAD and ix = ox·STRIDE+kx−PAD. Compute them signed, at least $clog2(W_IN+PAD)+2 bits.
- `pad_zero` = (iy<0) | (iy≥W_IN) | (ix<0) | (ix≥W_IN).
  - If `pad_zero`=1, `ifm_addr`=0.
  - Otherwise `ifm_addr` = (iy·W_IN+ix)·CHIN+c, truncated to ADDR_W.
- States:
  - IDLE: counters held at 0; `start` moves to RUN.
  - RUN: `layer_en` = !`stall`. Counters advance only when `layer_en`=1. If `layer_en`=1 on the final tap (oy=ox=WOUT−1, ky=kx=KERNEL_DIM−1, c=CHIN−1), the next state is DONE.
  - DONE: `done`=1 for exactly one cycle, counters clear to 0, next state is IDLE.
- `start` in RUN or DONE is ignored. `stall` outside RUN has no effect.
- `ifm_addr`, `pad_zero` and `tap_last` are combinational from the registered counters. They are meaningful only while `layer_en`=1 and are held stable during `stall`.

## Timing
- Reset values: state=IDLE, all counters 0, `layer_en`=0, `busy`=0, `done`=0, `ifm_addr`=0, `pad_zero`=0, `tap_last`=0.
- Start latency: `start` high at edge t gives RUN from t+1. The first tap (oy=ox=ky=kx=c=0) is presented in cycle t+1 with `layer_en`=1 (if no stall).
- Throughput: one tap per cycle. With no stalls a layer takes exactly WOUT²·KERNEL_DIM²·CHIN `layer_en` cycles; `done` follows in the next cycle.
- Stalls: a stall of n cycles extends RUN by n cycles. During a stall all outputs keep their values except `layer_en`, which is 0.
- Stall on the final tap: the final tap is simply re-presented when the stall ends. DONE is entered only after a non-stalled final tap.
- Downstream alignment: the ifm RAM has 1-cycle read latency, so its data aligns with the core's registered ROM output, which advances on the same `layer_en`.
- `tap_last` coincides with the cycle on which the core's clear-counter reaches KERNEL_DIM²·CHIN−1.
- Back-to-back layers: `start` may be asserted in the cycle after `done`, when the block is in IDLE.
- Reset mid-operation: return to IDLE at once, with all outputs at their reset values. No `done` is produced.

## Test plan
Bench parameters: W_IN=4, CHIN=2, K=3, STRIDE=1, PAD=1, giving WOUT=4, 18 taps per pixel and 288 taps in total.
- **Nominal run.** Pulse `start` with no stall. Require 288 consecutive `layer_en` cycles, then `done` high for 1 cycle, then IDLE. `tap_last` must pulse 16 times, on taps 17, 35, …, 287.
- **Address and padding check, pixel (0,0).**
  - Taps 0–5 (ky=0) have `pad_zero`=1.
  - Tap 8 (ky=1, kx=1, c=0) has `ifm_addr`=0, `pad_zero`=0.
  - Tap 17 (ky=2, kx=2, c=1) has `ifm_addr`=11.
  - For pixel (0,1), tap 9 has `ifm_addr`=3.
- **Stall.**
  - Hold `stall` for 3 cycles at tap 40: `layer_en` is 0 and `ifm_addr` is frozen for those cycles, and `done` arrives 3 cycles later than in the nominal run.
  - Stall on tap 287: DONE is delayed until `stall` falls.
- **Start while busy.** Pulse `start` mid-run: the sequence is unchanged and exactly one `done` is produced. `start` the cycle after `done` runs a second full layer.
- **Async reset.** Drive `rst` low at tap 100, mid-cycle: outputs go to reset values immediately. A fresh `start` restarts at tap 0.
- **Stride 2.** Rerun with STRIDE=2, PAD=0, W_IN=5 (WOUT=2). Pixel (1,1) tap 0 has `ifm_addr`=(2·5+2)·2=24, and there are 72 taps in total.

Source files
------------

// File: rtl/conv_tap_sequencer_if.sv
// rtl/conv_tap_sequencer_if.sv - start/stall control and tap address bus of the conv tap sequencer
interface conv_tap_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic              stall;
  logic              layer_en;
  logic [ADDR_W-1:0] ifm_addr;
  logic              pad_zero;
  logic              tap_last;
  logic              busy;
  logic              done;

  // master is the sequencer, slave is the controller / feature-map RAM side
  modport master (
    input  start, stall,
    output layer_en, ifm_addr, pad_zero, tap_last, busy, done
  );

  modport slave (
    output start, stall,
    input  layer_en, ifm_addr, pad_zero, tap_last, busy, done
  );
endinterface

// File: rtl/conv_tap_sequencer.sv
// rtl/conv_tap_sequencer.sv - raster pixel / kernel tap / channel walker for one convolution layer
module conv_tap_sequencer #(
  parameter int W_IN       = 128,
  parameter int CHIN       = 64,
  parameter int KERNEL_DIM = 3,
  parameter int STRIDE     = 1,
  parameter int PAD        = 1,
  parameter int WOUT       = (W_IN + 2*PAD - KERNEL_DIM)/STRIDE + 1,
  parameter int ADDR_W     = $clog2(W_IN*W_IN*CHIN)
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_tap_sequencer_if.master bus
);

  localparam int OW    = (WOUT > 1) ? $clog2(WOUT) : 1;
  localparam int KW    = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;
  localparam int CW    = (CHIN > 1) ? $clog2(CHIN) : 1;
  localparam int CRD_W = $clog2(W_IN + PAD) + 2;

  localparam logic [OW-1:0]           O_LAST = OW'(WOUT - 1);
  localparam logic [KW-1:0]           K_LAST = KW'(KERNEL_DIM - 1);
  localparam logic [CW-1:0]           C_LAST = CW'(CHIN - 1);
  localparam logic signed [CRD_W-1:0] W_IN_S = CRD_W'(W_IN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [OW-1:0] oy, ox;
  logic [KW-1:0] ky, kx;
  logic [CW-1:0] c;

  logic run_en;
  logic c_last, kx_last, ky_last, ox_last, oy_last;
  logic tap_last_raw, final_tap;
  logic signed [CRD_W-1:0] iy, ix;
  logic pad_raw;

  assign run_en       = (state == RUN) && !bus.stall;
  assign c_last       = (c  == C_LAST);
  assign kx_last      = (kx == K_LAST);
  assign ky_last      = (ky == K_LAST);
  assign ox_last      = (ox == O_LAST);
  assign oy_last      = (oy == O_LAST);
  assign tap_last_raw = c_last && kx_last && ky_last;
  assign final_tap    = tap_last_raw && ox_last && oy_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (run_en && final_tap) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Carry chain c -> kx -> ky -> ox -> oy; the final tap wraps every counter back to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oy <= '0;
      ox <= '0;
      ky <= '0;
      kx <= '0;
      c  <= '0;
    end else if (state != RUN) begin
      oy <= '0;
      ox <= '0;
      ky <= '0;
      kx <= '0;
      c  <= '0;
    end else if (run_en) begin
      if (!c_last) begin
        c <= c + CW'(1);
      end else begin
        c <= '0;
        if (!kx_last) begin
          kx <= kx + KW'(1);
        end else begin
          kx <= '0;
          if (!ky_last) begin
            ky <= ky + KW'(1);
          end else begin
            ky <= '0;
            if (!ox_last) begin
              ox <= ox + OW'(1);
            end else begin
              ox <= '0;
              oy <= oy_last ? '0 : oy + OW'(1);
            end
          end
        end
      end
    end
  end

  always_comb begin
    iy      = CRD_W'(int'(oy) * STRIDE + int'(ky) - PAD);
    ix      = CRD_W'(int'(ox) * STRIDE + int'(kx) - PAD);
    pad_raw = iy[CRD_W-1] || ix[CRD_W-1] || (iy >= W_IN_S) || (ix >= W_IN_S);
  end

  // Tap outputs are forced to their reset values outside RUN so IDLE/DONE show no stray padding.
  always_comb begin
    bus.layer_en = run_en;
    bus.busy     = (state != IDLE);
    bus.done     = (state == DONE);
    bus.pad_zero = (state == RUN) && pad_raw;
    bus.tap_last = (state == RUN) && tap_last_raw;
    bus.ifm_addr = '0;
    if (state == RUN && !pad_raw) begin
      bus.ifm_addr = ADDR_W'((int'(iy) * W_IN + int'(ix)) * CHIN + int'(c));
    end
  end

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// tb/tb_conv_tap_sequencer.sv - directed self-checking bench for conv_tap_sequencer
module tb_conv_tap_sequencer;

  localparam int A_TAPS = 288;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  conv_tap_sequencer_if #(.ADDR_W(5)) bus_a ();
  conv_tap_sequencer_if #(.ADDR_W(6)) bus_b ();

  conv_tap_sequencer #(
    .W_IN(4), .CHIN(2), .KERNEL_DIM(3), .STRIDE(1), .PAD(1), .WOUT(4), .ADDR_W(5)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  conv_tap_sequencer #(
    .W_IN(5), .CHIN(2), .KERNEL_DIM(3), .STRIDE(2), .PAD(0), .WOUT(2), .ADDR_W(6)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] addr_log [A_TAPS];
  logic       pad_log  [A_TAPS];

  int r_taps, r_done_cycle, r_done_cnt, r_last_cnt, r_last_bad, r_model_bad, r_stall_bad;
  logic r_post_ok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected {pad_zero, ifm_addr} of tap t for the 4x4x2, K3, S1, P1 layer.
  function automatic logic [5:0] model_a(input int t);
    int pix, r, oy, ox, ky, kx, c, iy, ix;
    pix = t / 18;
    r   = t % 18;
    oy  = pix / 4;
    ox  = pix % 4;
    ky  = r / 6;
    kx  = (r % 6) / 2;
    c   = r % 2;
    iy  = oy + ky - 1;
    ix  = ox + kx - 1;
    if (iy < 0 || iy >= 4 || ix < 0 || ix >= 4) return 6'b100000;
    return {1'b0, 5'((iy * 4 + ix) * 2 + c)};
  endfunction

  // Entered and left at posedge+1; cycle 0 is the cycle the first tap is presented.
  task automatic run_a(input int stall_at, input int stall_len, input int busy_start_at,
                       input int budget);
    int   tap, cyc, left;
    logic fired;
    r_done_cycle = -1;
    r_done_cnt   = 0;
    r_last_cnt   = 0;
    r_last_bad   = 0;
    r_model_bad  = 0;
    r_stall_bad  = 0;
    left  = stall_len;
    fired = 1'b0;
    tap   = 0;
    cyc   = 0;
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    while (r_done_cnt == 0 && cyc < budget) begin
      bus_a.stall = (tap == stall_at && left > 0);
      if (bus_a.stall) left--;
      bus_a.start = (tap == busy_start_at && !fired);
      if (bus_a.start) fired = 1'b1;
      #1;
      if (bus_a.stall) begin
        if (bus_a.layer_en !== 1'b0) r_stall_bad++;
        if ({bus_a.pad_zero, bus_a.ifm_addr} !== model_a(tap)) r_stall_bad++;
      end
      if (bus_a.layer_en === 1'b1) begin
        if (tap < A_TAPS) begin
          addr_log[tap] = bus_a.ifm_addr;
          pad_log[tap]  = bus_a.pad_zero;
          if ({bus_a.pad_zero, bus_a.ifm_addr} !== model_a(tap)) r_model_bad++;
          if (bus_a.tap_last !== ((tap % 18) == 17)) r_last_bad++;
        end
        if (bus_a.tap_last === 1'b1) r_last_cnt++;
        tap++;
      end
      if (bus_a.done === 1'b1) begin
        r_done_cnt++;
        r_done_cycle = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus_a.stall = 1'b0;
    bus_a.start = 1'b0;
    r_taps    = tap;
    r_post_ok = (bus_a.busy === 1'b0) && (bus_a.done === 1'b0) && (bus_a.layer_en === 1'b0);
  endtask

  initial begin
    int   tap, cyc, pads, done_seen, b_done;
    logic [5:0] b54, b71;

    rst = 1'b0;
    bus_a.start = 1'b0;
    bus_a.stall = 1'b0;
    bus_b.start = 1'b0;
    bus_b.stall = 1'b0;

    #12;
    check("rst_layer_en", bus_a.layer_en, 0);
    check("rst_busy",     bus_a.busy,     0);
    check("rst_done",     bus_a.done,     0);
    check("rst_addr",     bus_a.ifm_addr, 0);
    check("rst_pad",      bus_a.pad_zero, 0);
    check("rst_tap_last", bus_a.tap_last, 0);

    @(posedge clk); #1;
    rst = 1'b1;
    bus_a.stall = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("idle_stall_busy", bus_a.busy,     0);
    check("idle_stall_en",   bus_a.layer_en, 0);
    bus_a.stall = 1'b0;

    // Nominal layer.
    run_a(-1, 0, -1, 400);
    check("nom_taps",      r_taps,       288);
    check("nom_done_cyc",  r_done_cycle, 288);
    check("nom_last_cnt",  r_last_cnt,   16);
    check("nom_last_pos",  r_last_bad,   0);
    check("nom_model",     r_model_bad,  0);
    check("nom_post_idle", r_post_ok,    1);
    pads = 0;
    for (int i = 0; i < 6; i++) if (pad_log[i] === 1'b1) pads++;
    check("pix00_pad_ky0", pads,         6);
    check("pix00_t8_addr", addr_log[8],  0);
    check("pix00_t8_pad",  pad_log[8],   0);
    check("pix00_t17_addr", addr_log[17], 11);
    check("pix01_t9_addr", addr_log[27], 3);

    // Three-cycle stall at tap 40.
    run_a(40, 3, -1, 400);
    check("st40_taps",     r_taps,       288);
    check("st40_done_cyc", r_done_cycle, 291);
    check("st40_frozen",   r_stall_bad,  0);
    check("st40_model",    r_model_bad,  0);

    // Stall on the final tap.
    run_a(287, 4, -1, 400);
    check("st287_done_cyc", r_done_cycle, 292);
    check("st287_frozen",   r_stall_bad,  0);
    check("st287_taps",     r_taps,       288);

    // Start while busy, then a back-to-back layer.
    run_a(-1, 0, 100, 400);
    check("busy_start_taps",  r_taps,       288);
    check("busy_start_done",  r_done_cycle, 288);
    check("busy_start_model", r_model_bad,  0);
    check("busy_start_post",  r_post_ok,    1);
    run_a(-1, 0, -1, 400);
    check("b2b_taps",     r_taps,       288);
    check("b2b_done_cyc", r_done_cycle, 288);
    check("b2b_model",    r_model_bad,  0);

    // Asynchronous reset in the middle of tap 100.
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    tap = 0;
    cyc = 0;
    while (tap < 100 && cyc < 300) begin
      #1;
      if (bus_a.layer_en === 1'b1) tap++;
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_reach_t100", tap, 100);
    #1;
    check("pre_rst_addr", bus_a.ifm_addr, 12);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_en",       bus_a.layer_en, 0);
    check("mid_rst_busy",     bus_a.busy,     0);
    check("mid_rst_addr",     bus_a.ifm_addr, 0);
    check("mid_rst_pad",      bus_a.pad_zero, 0);
    check("mid_rst_tap_last", bus_a.tap_last, 0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus_a.done === 1'b1 || bus_a.busy === 1'b1) done_seen++;
    end
    check("mid_rst_no_done", done_seen, 0);
    rst = 1'b1;
    run_a(-1, 0, -1, 400);
    check("restart_taps",  r_taps,       288);
    check("restart_done",  r_done_cycle, 288);
    check("restart_model", r_model_bad,  0);

    // Stride 2, no padding, 5x5 input.
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    tap    = 0;
    cyc    = 0;
    b_done = -1;
    b54    = '1;
    b71    = '1;
    while (b_done < 0 && cyc < 200) begin
      #1;
      if (bus_b.layer_en === 1'b1) begin
        if (tap == 54) b54 = bus_b.ifm_addr;
        if (tap == 71) b71 = bus_b.ifm_addr;
        tap++;
      end
      if (bus_b.done === 1'b1) b_done = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    check("s2_taps",     tap,    72);
    check("s2_p11_t0",   b54,    24);
    check("s2_p11_t17",  b71,    49);
    check("s2_done_cyc", b_done, 72);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
